// File: rtl/cmd_frame_decoder_if.sv
// Byte-stream, register-file and transmit signals of the command frame decoder.
// The decoder connects through the master modport; the environment that
// feeds bytes, models the register file and drains tx bytes uses the slave modport.
interface cmd_frame_decoder_if #(
   parameter int data_width = 8,
   parameter int addr_width = 4
);
   // incoming byte stream
   logic                  enable_in;
   logic [data_width-1:0] data_in;

   // register-file port
   logic                  rf_wr_en;
   logic                  rf_rd_en;
   logic [addr_width-1:0] rf_addr;
   logic [data_width-1:0] rf_wr_data;
   logic [data_width-1:0] rf_rd_data;
   logic                  rf_rd_valid;

   // transmit port toward the serializer
   logic [data_width-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   // status
   logic                  frame_error;
   logic                  busy;

   modport master (
      input  enable_in, data_in, rf_rd_data, rf_rd_valid, tx_ready,
      output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_valid,
             frame_error, busy
   );

   modport slave (
      output enable_in, data_in, rf_rd_data, rf_rd_valid, tx_ready,
      input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_valid,
             frame_error, busy
   );
endinterface

// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: parses write frames (wr_cmd, addr, data) and read
// frames (rd_cmd, addr) from a byte-pulse stream into register-file strobes,
// returns read data as one byte on a valid/ready port, and flags malformed,
// stray or stalled frames with a one-cycle frame_error pulse.
module cmd_frame_decoder #(
   parameter int                    data_width = 8,
   parameter int                    addr_width = 4,
   parameter int                    timeout    = 255,
   parameter logic [data_width-1:0] wr_cmd     = 8'hAA,
   parameter logic [data_width-1:0] rd_cmd     = 8'hBB
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   cmd_frame_decoder_if.master  bus
);

   // counter only has to reach timeout-1; expiry is detected on that value
   localparam int TMO_W = (timeout > 2) ? $clog2(timeout) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  rf_wr_en_q, rf_wr_en_d;
   logic                  rf_rd_en_q, rf_rd_en_d;
   logic                  frame_error_q, frame_error_d;
   logic [addr_width-1:0] rf_addr_q, rf_addr_d;
   logic [data_width-1:0] rf_wr_data_q, rf_wr_data_d;
   logic [data_width-1:0] tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  busy_q, busy_d;

   logic                  addr_ok;
   logic                  timed;
   logic                  expired;

   // address bytes are legal only when the bits above the address field are zero
   assign addr_ok = ((bus.data_in >> addr_width) == '0);
   // states guarded by the inter-byte / read-data watchdog
   assign timed   = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                    (state_q == RD_ADDR) || (state_q == RD_WAIT);
   assign expired = timed && (tmo_q == TMO_LAST);

   // next-state and registered-output decode; a qualifying event always beats expiry
   always_comb begin
      state_d       = state_q;
      rf_wr_en_d    = 1'b0;
      rf_rd_en_d    = 1'b0;
      frame_error_d = 1'b0;
      rf_addr_d     = rf_addr_q;
      rf_wr_data_d  = rf_wr_data_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.enable_in) begin
               if (bus.data_in == wr_cmd) begin
                  state_d = WR_ADDR;
               end else if (bus.data_in == rd_cmd) begin
                  state_d = RD_ADDR;
               end else begin
                  frame_error_d = 1'b1;
               end
            end
         end
         WR_ADDR: begin
            if (bus.enable_in) begin
               if (addr_ok) begin
                  rf_addr_d = bus.data_in[addr_width-1:0];
                  state_d   = WR_DATA;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = IDLE;
               end
            end else if (expired) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         WR_DATA: begin
            if (bus.enable_in) begin
               rf_wr_data_d = bus.data_in;
               rf_wr_en_d   = 1'b1;
               state_d      = IDLE;
            end else if (expired) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.enable_in) begin
               if (addr_ok) begin
                  rf_addr_d  = bus.data_in[addr_width-1:0];
                  rf_rd_en_d = 1'b1;
                  state_d    = RD_WAIT;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = IDLE;
               end
            end else if (expired) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         RD_WAIT: begin
            // a stray byte here is dropped and flagged but does not end the wait
            if (bus.enable_in) begin
               frame_error_d = 1'b1;
            end
            if (bus.rf_rd_valid) begin
               tx_data_d  = bus.rf_rd_data;
               tx_valid_d = 1'b1;
               state_d    = TX_SEND;
            end else if (expired) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         TX_SEND: begin
            if (bus.enable_in) begin
               frame_error_d = 1'b1;
            end
            if (tx_valid_q && bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // watchdog restarts on every state entry and only runs in guarded states
      if ((state_d != state_q) || !timed) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   // state and output registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= IDLE;
         tmo_q         <= '0;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         frame_error_q <= 1'b0;
         rf_addr_q     <= '0;
         rf_wr_data_q  <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmo_q         <= tmo_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         frame_error_q <= frame_error_d;
         rf_addr_q     <= rf_addr_d;
         rf_wr_data_q  <= rf_wr_data_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.rf_wr_en    = rf_wr_en_q;
   assign bus.rf_rd_en    = rf_rd_en_q;
   assign bus.rf_addr     = rf_addr_q;
   assign bus.rf_wr_data  = rf_wr_data_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.frame_error = frame_error_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with timeout = 8. Expected strobes,
// error pulses and tx bytes are queued when stimulus is driven and popped by
// a negedge monitor when the decoder produces them.
module tb_cmd_frame_decoder;

   logic clk_in;
   logic rst_in;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int         cyc;
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_wr_q[$];
   exp_t       exp_rd_q[$];
   int         exp_err_q[$];
   logic [7:0] exp_tx_q[$];

   cmd_frame_decoder_if #(.data_width(8), .addr_width(4)) bus ();

   cmd_frame_decoder #(
      .data_width (8),
      .addr_width (4),
      .timeout    (8),
      .wr_cmd     (8'hAA),
      .rd_cmd     (8'hBB)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // rising-edge counter used to timestamp expected events
   always @(posedge clk_in) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog observed=time_limit required=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // drive one byte, sampled at the next rising edge (edge number cyc+1)
   task automatic send(input logic [7:0] b);
      bus.enable_in = 1'b1;
      bus.data_in   = b;
      tick();
      $display("byte %02h accepted at edge %0d", b, cyc);
      bus.enable_in = 1'b0;
      bus.data_in   = 8'($urandom);
   endtask

   // scoreboard monitor, sampling away from the rising edge
   always @(negedge clk_in) begin
      exp_t e;
      if (bus.rf_wr_en) begin
         check("wr_expected", 32'(exp_wr_q.size() > 0), 1);
         if (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            check("wr_addr", bus.rf_addr, e.addr);
            check("wr_data", bus.rf_wr_data, e.data);
            check("wr_cycle", cyc, e.cyc);
            $display("write addr=%0h data=%02h cycle=%0d", bus.rf_addr, bus.rf_wr_data, cyc);
         end
      end
      if (bus.rf_rd_en) begin
         check("rd_expected", 32'(exp_rd_q.size() > 0), 1);
         if (exp_rd_q.size() > 0) begin
            e = exp_rd_q.pop_front();
            check("rd_addr", bus.rf_addr, e.addr);
            check("rd_cycle", cyc, e.cyc);
            $display("read strobe addr=%0h cycle=%0d", bus.rf_addr, cyc);
         end
      end
      if (bus.frame_error) begin
         check("err_expected", 32'(exp_err_q.size() > 0), 1);
         if (exp_err_q.size() > 0) begin
            check("err_cycle", cyc, exp_err_q.pop_front());
            $display("frame_error cycle=%0d", cyc);
         end
      end
      if (bus.tx_valid && bus.tx_ready) begin
         check("tx_expected", 32'(exp_tx_q.size() > 0), 1);
         if (exp_tx_q.size() > 0) begin
            check("tx_data", bus.tx_data, exp_tx_q.pop_front());
            $display("tx byte %02h cycle=%0d", bus.tx_data, cyc);
         end
      end
   end

   initial begin
      rst_in          = 1'b0;
      bus.enable_in   = 1'b0;
      bus.data_in     = 8'h00;
      bus.rf_rd_data  = 8'h00;
      bus.rf_rd_valid = 1'b0;
      bus.tx_ready    = 1'b0;

      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         bus.enable_in   = 1'($urandom);
         bus.data_in     = 8'($urandom);
         bus.rf_rd_data  = 8'($urandom);
         bus.rf_rd_valid = 1'($urandom);
         bus.tx_ready    = 1'($urandom);
         tick();
         check("rst_wr_en", bus.rf_wr_en, 0);
         check("rst_rd_en", bus.rf_rd_en, 0);
         check("rst_err", bus.frame_error, 0);
         check("rst_tx_valid", bus.tx_valid, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_addr", bus.rf_addr, 0);
         check("rst_wr_data", bus.rf_wr_data, 0);
         check("rst_tx_data", bus.tx_data, 0);
      end
      bus.enable_in   = 1'b0;
      bus.rf_rd_valid = 1'b0;
      bus.tx_ready    = 1'b0;
      rst_in          = 1'b1;
      tick();
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_tx_valid", bus.tx_valid, 0);
      check("post_rst_addr", bus.rf_addr, 0);

      // write frame AA 03 5C back to back
      exp_wr_q.push_back('{cyc: cyc + 3, addr: 4'h3, data: 8'h5C});
      send(8'hAA);
      check("wr_busy_rise", bus.busy, 1);
      send(8'h03);
      send(8'h5C);
      check("wr_strobe", bus.rf_wr_en, 1);
      check("wr_busy_fall", bus.busy, 0);
      tick();
      check("wr_strobe_one_cycle", bus.rf_wr_en, 0);
      check("wr_addr_hold", bus.rf_addr, 3);
      check("wr_data_hold", bus.rf_wr_data, 8'h5C);

      // read frame BB 07, data returned two cycles after the strobe
      exp_rd_q.push_back('{cyc: cyc + 2, addr: 4'h7, data: 8'h00});
      send(8'hBB);
      send(8'h07);
      check("rd_strobe", bus.rf_rd_en, 1);
      tick();
      check("rd_strobe_one_cycle", bus.rf_rd_en, 0);
      bus.rf_rd_valid = 1'b1;
      bus.rf_rd_data  = 8'hA5;
      exp_tx_q.push_back(8'hA5);
      tick();
      bus.rf_rd_valid = 1'b0;
      bus.rf_rd_data  = 8'h00;
      check("tx_valid_rise", bus.tx_valid, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("tx_valid_stall", bus.tx_valid, 1);
         check("tx_data_stall", bus.tx_data, 8'hA5);
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      check("tx_valid_drop", bus.tx_valid, 0);
      check("tx_busy_drop", bus.busy, 0);

      // bad opcode
      exp_err_q.push_back(cyc + 1);
      send(8'h12);
      check("bad_op_busy", bus.busy, 0);
      check("bad_op_err", bus.frame_error, 1);

      // out-of-range write address, no strobe allowed
      exp_err_q.push_back(cyc + 2);
      send(8'hAA);
      send(8'h10);
      check("oor_busy", bus.busy, 0);
      tick();

      // stray byte during TX_SEND
      exp_rd_q.push_back('{cyc: cyc + 2, addr: 4'h5, data: 8'h00});
      send(8'hBB);
      send(8'h05);
      bus.rf_rd_valid = 1'b1;
      bus.rf_rd_data  = 8'h3C;
      exp_tx_q.push_back(8'h3C);
      tick();
      bus.rf_rd_valid = 1'b0;
      tick();
      exp_err_q.push_back(cyc + 1);
      send(8'h77);
      check("stray_tx_data", bus.tx_data, 8'h3C);
      check("stray_tx_valid", bus.tx_valid, 1);
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      check("stray_tx_done", bus.tx_valid, 0);

      // timeout after AA with nothing following
      exp_err_q.push_back(cyc + 1 + 8);
      send(8'hAA);
      repeat (7) tick();
      check("tmo_busy_before", bus.busy, 1);
      tick();
      check("tmo_busy_after", bus.busy, 0);

      // address byte on the expiry cycle wins over the timeout
      send(8'hAA);
      repeat (7) tick();
      exp_wr_q.push_back('{cyc: cyc + 2, addr: 4'h4, data: 8'h99});
      send(8'h04);
      check("tmo_edge_busy", bus.busy, 1);
      check("tmo_edge_no_err", bus.frame_error, 0);
      send(8'h99);
      check("tmo_edge_wr", bus.rf_wr_en, 1);

      // reset in the middle of a write frame
      send(8'hAA);
      send(8'h02);
      rst_in = 1'b0;
      tick();
      check("midrst_busy", bus.busy, 0);
      rst_in = 1'b1;
      repeat (2) tick();
      exp_wr_q.push_back('{cyc: cyc + 3, addr: 4'hB, data: 8'hC3});
      send(8'hAA);
      send(8'h0B);
      send(8'hC3);
      check("midrst_wr", bus.rf_wr_en, 1);

      repeat (12) tick();
      check("left_wr", exp_wr_q.size(), 0);
      check("left_rd", exp_rd_q.size(), 0);
      check("left_err", exp_err_q.size(), 0);
      check("left_tx", exp_tx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_frame_decoder.md
# cmd_frame_decoder

Byte-level command decoder that sits directly downstream of the data synchronizer. It consumes the one-cycle `enable_in` pulse and `data_in` byte produced in the destination clock domain and parses them into register-file write and read transactions. Read results are returned as single bytes on a valid/ready transmit port toward the serializer. Malformed, out-of-range, stray or stalled frames are flagged on `frame_error` and the decoder recovers to idle.

## Interface
- `data_width`, 8: byte width on all data paths.
- `addr_width`, 4: register-file address width; valid addresses are 0 .. 2**addr_width-1.
- `timeout`, 255: idle cycles allowed between bytes of one frame, and while waiting for read data; minimum 2.
- `wr_cmd`, 8'hAA: write command opcode.
- `rd_cmd`, 8'hBB: read command opcode.

- `clk_in`  in  1  destination-domain clock.
- `rst_in`  in  1  reset; one clock, asynchronous, active-low.
- `enable_in`  in  1  one-cycle byte-valid pulse from the synchronizer.
- `data_in`  in  data_width  byte; valid only while `enable_in`=1.
- `rf_rd_data`  in  data_width  register-file read data.
- `rf_rd_valid`  in  1  `rf_rd_data` valid, one-cycle pulse.
- `tx_ready`  in  1  transmitter accepts a byte.
- `rf_wr_en`  out  1  one-cycle write strobe.
- `rf_rd_en`  out  1  one-cycle read strobe.
- `rf_addr`  out  addr_width  register address.
- `rf_wr_data`  out  data_width  write data.
- `tx_data`  out  data_width  read result byte.
- `tx_valid`  out  1  `tx_data` valid.
- `frame_error`  out  1  one-cycle error pulse.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered. Asynchronous reset drives every output to 0 and the state to IDLE. Reset mid-frame discards the partial frame; no strobe is issued afterwards.
- **IDLE**
  - Byte == `wr_cmd` -> WR_ADDR.
  - Byte == `rd_cmd` -> RD_ADDR.
  - Any other byte -> `frame_error` pulse; remain in IDLE.
- **WR_ADDR**
  - Byte with upper `data_width-addr_width` bits equal to zero -> latch `rf_addr`; go to WR_DATA.
  - Otherwise -> `frame_error`; go to IDLE.
- **WR_DATA**
  - Byte -> `rf_wr_data` = byte and `rf_wr_en` = 1 for exactly one cycle; go to IDLE.
- **RD_ADDR**
  - Byte with an in-range address -> latch `rf_addr`; `rf_rd_en` = 1 for one cycle; go to RD_WAIT.
  - Out-of-range address -> `frame_error`; go to IDLE.
- **RD_WAIT**
  - `rf_rd_valid` -> `tx_data` = `rf_rd_data`; go to TX_SEND.
  - `enable_in` in this state -> byte dropped, `frame_error` pulse, state unchanged.
- **TX_SEND**
  - `tx_valid` = 1, with `tx_data` held stable, until a cycle with `tx_valid` & `tx_ready` = 1.
  - On that cycle: next cycle `tx_valid` = 0 and state = IDLE.
  - No timeout in this state.
  - `enable_in` in this state -> byte dropped, `frame_error` pulse.
- **Timeout**
  - Applies in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT only.
  - The counter clears on every state entry.
  - After `timeout` consecutive cycles with no qualifying event -> `frame_error` pulse; go to IDLE.
  - If a byte (or `rf_rd_valid`) arrives on the expiry cycle, the event wins and no error is raised.
- `rf_addr` and `rf_wr_data` hold their last values between transactions.

## Timing
- Byte accepted on edge N (`enable_in` = 1 sampled at N):
  - New state is visible after N.
  - `rf_wr_en` / `rf_rd_en` / `frame_error` are high for the cycle between edges N and N+1 only.
- Write latency: last byte at edge N -> write strobe at N+1.
- Read latency: address byte at edge N -> `rf_rd_en` at N+1. `rf_rd_valid` sampled at edge M -> `tx_valid` high from M+1.
- Back-to-back bytes on consecutive cycles are accepted; no bubble is required.
- A frame can start in the cycle after IDLE is re-entered.
- `busy` tracks the state register, so it rises the cycle after the opcode byte.

## Test plan
- **Reset:** hold `rst_in` = 0 with random inputs -> all outputs 0. Release -> still 0; `busy` = 0.
- **Write:** bytes AA, 03, 5C on consecutive cycles -> `rf_wr_en` = 1 for one cycle with `rf_addr` = 3 and `rf_wr_data` = 8'h5C. `busy` falls in the same cycle.
- **Read:**
  - Bytes BB, 07 -> `rf_rd_en` pulse with `rf_addr` = 7.
  - Return `rf_rd_valid` with 8'hA5 two cycles later.
  - Hold `tx_ready` = 0 for 5 cycles -> `tx_valid` = 1 and `tx_data` = A5 stay stable.
  - Then `tx_ready` = 1 -> `tx_valid` drops next cycle.
- **Errors:**
  - Opcode 8'h12 -> one `frame_error` pulse; state stays IDLE.
  - Bytes AA, 8'h10 (out of range) -> `frame_error`; no write strobe.
  - A byte sent during TX_SEND -> `frame_error`; `tx_data` unchanged.
- **Timeout:** with `timeout` = 8, send AA then nothing -> `frame_error` 8 cycles later; `busy` = 0. Repeat with the address byte arriving exactly on the expiry cycle -> no error; state = WR_DATA.
- **Reset mid-frame:** send AA, 02, then pulse `rst_in` low -> no `rf_wr_en` ever. A following full write frame completes normally.
